// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output driver.
// The level rule lives here so every consumer uses the same full-on special case.
package pwm_pkg;
   localparam int         PWM_STEP_W          = 8;
   localparam logic [7:0] PWM_DUTY_FULL       = 8'hFF;
   localparam int         PWM_CLK_DIV_DEFAULT = 13;
   localparam int         PWM_PINS            = 16;

   typedef logic [PWM_PINS-1:0] pin_vec_t;

   // 0xFF means fully on rather than 255/256 of a period.
   function automatic logic pwm_level_f(input logic [PWM_STEP_W-1:0] step,
                                        input logic [PWM_STEP_W-1:0] duty);
      return (duty == PWM_DUTY_FULL) || (step < duty);
   endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divider: tick is high for one clk out of every CLK_DIV.
// CLK_DIV = 1 degenerates to a constant tick.
module pwm_prescaler #(
   parameter int CLK_DIV = 13
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int            W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/pwm_output_driver.sv
// Drives 16 registered pins as off / static high / shared PWM from SPI registers.
// Duty is shadowed and only taken up at the 255->0 step wrap so pulses are never truncated.
module pwm_output_driver
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start,
   output logic        pwm_level
);
   logic                  tick;
   logic                  wrap;
   logic                  lvl;
   logic [PWM_STEP_W-1:0] step_q, step_d;
   logic [PWM_STEP_W-1:0] duty_q, duty_d;
   logic                  ps_q, ps_d;
   logic                  lvl_q;
   pin_vec_t              en_out, en_pwm;
   pin_vec_t              out_q, out_d;

   pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
   assign wrap   = tick && (step_q == 8'hFF);

   always_comb begin
      step_d = step_q;
      duty_d = duty_q;
      ps_d   = wrap;
      if (tick) step_d = step_q + 8'd1;
      // The duty present on the wrap cycle itself is the one captured.
      if (wrap) duty_d = pwm_duty_cycle;
      lvl   = pwm_level_f(step_q, duty_q);
      out_d = en_out & (~en_pwm | {PWM_PINS{lvl}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= '0;
         duty_q <= '0;
         ps_q   <= 1'b0;
         lvl_q  <= 1'b0;
         out_q  <= '0;
      end else begin
         step_q <= step_d;
         duty_q <= duty_d;
         ps_q   <= ps_d;
         lvl_q  <= lvl;
         out_q  <= out_d;
      end
   end

   assign out          = out_q;
   assign period_start = ps_q;
   assign pwm_level    = lvl_q;
endmodule

// File: tb/tb_pwm_output_driver.sv
// Randomised bench for pwm_output_driver with CLK_DIV=13 (a) and CLK_DIV=1 (b) side by side.
// Reference model derives state from the cycle count since reset.
module tb_pwm_output_driver;
   localparam int DIV_A = 13;
   localparam int DIV_B = 1;
   localparam int PER_A = 256 * DIV_A;
   localparam int PER_B = 256 * DIV_B;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] en_out = '0, en_pwm = '0;
   logic [7:0]  duty = '0;
   logic [15:0] out_a, out_b;
   logic        ps_a, ps_b, lvl_a, lvl_b;
   int          checks = 0, passed = 0;

   always #5 clk = ~clk;

   pwm_output_driver #(.CLK_DIV(DIV_A)) dut_a (
      .clk(clk), .rst(rst),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out_a), .period_start(ps_a), .pwm_level(lvl_a)
   );

   pwm_output_driver #(.CLK_DIV(DIV_B)) dut_b (
      .clk(clk), .rst(rst),
      .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
      .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
      .pwm_duty_cycle(duty), .out(out_b), .period_start(ps_b), .pwm_level(lvl_b)
   );

   // Reference: after n cycles out of reset the step is (n/div)%256; duty is re-latched every period.
   int          n_a, n_b;
   logic [7:0]  sh_a, sh_b;
   logic [15:0] eo_a, eo_b;
   logic        el_a, el_b, ep_a, ep_b;

   function automatic logic ref_level(input int n, input int div, input logic [7:0] sh);
      int step;
      step = (n / div) % 256;
      if (sh == 8'hFF) return 1'b1;
      return step < int'(sh);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_a <= 0; sh_a <= '0; eo_a <= '0; el_a <= 1'b0; ep_a <= 1'b0;
         n_b <= 0; sh_b <= '0; eo_b <= '0; el_b <= 1'b0; ep_b <= 1'b0;
      end else begin
         el_a <= ref_level(n_a, DIV_A, sh_a);
         eo_a <= en_out & (~en_pwm | {16{ref_level(n_a, DIV_A, sh_a)}});
         ep_a <= ((n_a + 1) % PER_A) == 0;
         if (((n_a + 1) % PER_A) == 0) sh_a <= duty;
         n_a  <= n_a + 1;
         el_b <= ref_level(n_b, DIV_B, sh_b);
         eo_b <= en_out & (~en_pwm | {16{ref_level(n_b, DIV_B, sh_b)}});
         ep_b <= ((n_b + 1) % PER_B) == 0;
         if (((n_b + 1) % PER_B) == 0) sh_b <= duty;
         n_b  <= n_b + 1;
      end
   end

   wire [35:0] dut_v = {out_a, lvl_a, ps_a, out_b, lvl_b, ps_b};
   wire [35:0] ref_v = {eo_a, el_a, ep_a, eo_b, el_b, ep_b};

   task automatic test_reset();
      int first_a, first_b;
      repeat (2) @(negedge clk);
      rst = 1'b0; duty = 8'h80; en_out = 16'hFFFF; en_pwm = 16'hFFFF;
      repeat (500) begin
         @(negedge clk);
         checks++; if (dut_v !== ref_v) $display("FAIL reset_pre t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
      end
      #2 rst = 1'b1;
      #1;
      checks++; if ({out_a, out_b} !== 32'h0) $display("FAIL reset_async got=%h exp=0", {out_a, out_b}); else passed++;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({out_a, lvl_a, ps_a, out_b, lvl_b, ps_b} !== 36'h0)
            $display("FAIL reset_hold got=%h exp=0", dut_v);
         else passed++;
      end
      rst = 1'b0;
      first_a = 0; first_b = 0;
      for (int k = 1; k <= PER_A + 10; k++) begin
         @(negedge clk);
         checks++; if (dut_v !== ref_v) $display("FAIL reset_run t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
         if (ps_a && first_a == 0) first_a = k;
         if (ps_b && first_b == 0) first_b = k;
      end
      checks++; if (first_a !== PER_A) $display("FAIL first_ps_a got=%0d exp=%0d", first_a, PER_A); else passed++;
      checks++; if (first_b !== PER_B) $display("FAIL first_ps_b got=%0d exp=%0d", first_b, PER_B); else passed++;
   endtask

   task automatic test_static();
      int bad;
      @(negedge clk);
      rst = 1'b1; duty = 8'h00; en_out = 16'h00FF; en_pwm = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (out_a !== 16'h00FF) $display("FAIL static_a got=%h exp=00ff", out_a); else passed++;
      checks++; if (out_b !== 16'h00FF) $display("FAIL static_b got=%h exp=00ff", out_b); else passed++;
      en_out = 16'hFFFF; en_pwm = 16'hFFFF;
      bad = 0;
      repeat (PER_A) begin
         @(negedge clk);
         if (out_a !== 16'h0 || out_b !== 16'h0) bad++;
         checks++; if (dut_v !== ref_v) $display("FAIL static_run t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
      end
      checks++; if (bad !== 0) $display("FAIL static_zero got=%0d nonzero cycles exp=0", bad); else passed++;
   endtask

   task automatic test_duty();
      int hi [16];
      bit found;
      duty = 8'h40;
      found = 0;
      for (int k = 0; k < PER_A + 5 && !found; k++) begin
         @(negedge clk);
         checks++; if (dut_v !== ref_v) $display("FAIL duty_wait t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
         if (ps_a) found = 1;
      end
      checks++; if (!found) $display("FAIL duty_ps got=none exp=pulse"); else passed++;
      duty = 8'hFF;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 16; i++) hi[i] = 0;
         repeat (PER_A) begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) hi[i] += int'(out_a[i]);
            checks++; if (dut_v !== ref_v) $display("FAIL duty_run t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
         end
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (hi[i] !== ((w == 0) ? 64 * DIV_A : PER_A))
               $display("FAIL duty_high w%0d pin%0d got=%0d exp=%0d", w, i, hi[i], (w == 0) ? 64 * DIV_A : PER_A);
            else passed++;
         end
      end
   endtask

   task automatic test_shadow();
      int hi;
      bit found;
      duty = 8'h20;
      found = 0;
      for (int k = 0; k < PER_A + 5 && !found; k++) begin
         @(negedge clk);
         checks++; if (dut_v !== ref_v) $display("FAIL shadow_wait t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
         if (ps_a) found = 1;
      end
      checks++; if (!found) $display("FAIL shadow_ps got=none exp=pulse"); else passed++;
      for (int w = 0; w < 2; w++) begin
         hi = 0;
         for (int i = 1; i <= PER_A; i++) begin
            @(negedge clk);
            hi += int'(lvl_a);
            if (w == 0 && i == 100 * DIV_A) duty = 8'hC0;
            checks++; if (dut_v !== ref_v) $display("FAIL shadow_run t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
         end
         checks++;
         if (hi !== ((w == 0) ? 32'h20 * DIV_A : 32'hC0 * DIV_A))
            $display("FAIL shadow_high w%0d got=%0d exp=%0d", w, hi, (w == 0) ? 32'h20 * DIV_A : 32'hC0 * DIV_A);
         else passed++;
      end
   endtask

   task automatic test_wrap();
      int hi;
      bit found;
      duty = 8'hE0;
      found = 0;
      for (int k = 0; k < PER_A + 5 && !found; k++) begin
         @(negedge clk);
         checks++; if (dut_v !== ref_v) $display("FAIL wrap_wait t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
         if (ps_a) found = 1;
      end
      checks++; if (!found) $display("FAIL wrap_ps got=none exp=pulse"); else passed++;
      for (int i = 1; i < PER_A; i++) begin
         @(negedge clk);
         checks++; if (dut_v !== ref_v) $display("FAIL wrap_run t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
      end
      duty = 8'h10;
      @(negedge clk);
      duty = 8'h33;
      checks++; if (ps_a !== 1'b1) $display("FAIL wrap_edge got=%b exp=1", ps_a); else passed++;
      hi = 0;
      repeat (PER_A) begin
         @(negedge clk);
         hi += int'(lvl_a);
         checks++; if (dut_v !== ref_v) $display("FAIL wrap_run2 t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
      end
      checks++; if (hi !== 16 * DIV_A) $display("FAIL wrap_high got=%0d exp=%0d", hi, 16 * DIV_A); else passed++;
   endtask

   task automatic test_mixed();
      int hi, bad, ps_cnt, ps_at;
      bit found;
      en_out = 16'hA5A5; en_pwm = 16'hFF00; duty = 8'h80;
      found = 0;
      for (int k = 0; k < PER_B + 5 && !found; k++) begin
         @(negedge clk);
         checks++; if (dut_v !== ref_v) $display("FAIL mixed_wait t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
         if (ps_b) found = 1;
      end
      checks++; if (!found) $display("FAIL mixed_ps got=none exp=pulse"); else passed++;
      hi = 0; bad = 0; ps_cnt = 0; ps_at = 0;
      for (int i = 1; i <= PER_B; i++) begin
         @(negedge clk);
         if (out_b !== (16'h00A5 | (el_b ? 16'hA500 : 16'h0000))) bad++;
         hi += int'(out_b[15]);
         if (ps_b) begin ps_cnt++; ps_at = i; end
         checks++; if (dut_v !== ref_v) $display("FAIL mixed_run t=%0t got=%h exp=%h", $time, dut_v, ref_v); else passed++;
      end
      checks++; if (bad !== 0) $display("FAIL mixed_pins got=%0d bad cycles exp=0", bad); else passed++;
      checks++; if (hi !== 128) $display("FAIL mixed_high got=%0d exp=128", hi); else passed++;
      checks++; if (ps_cnt !== 1 || ps_at !== PER_B) $display("FAIL mixed_period got=%0d@%0d exp=1@%0d", ps_cnt, ps_at, PER_B); else passed++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 24; it++) begin
         @(negedge clk);
         en_out = 16'($urandom);
         en_pwm = 16'($urandom);
         duty   = (it % 5 == 0) ? 8'hFF : 8'($urandom);
         if (it == 12) begin
            #1 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         repeat ($urandom_range(20, 400)) begin
            @(negedge clk);
            checks++; if (dut_v !== ref_v) $display("FAIL random_run it=%0d t=%0t got=%h exp=%h", it, $time, dut_v, ref_v); else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_static();
      test_duty();
      test_shadow();
      test_wrap();
      test_mixed();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
